// File: rtl/sec_alert_handler_pkg.sv
// Shared types and defaults for the security-alert receive path.
// The abort entry layout {rob_idx, yrot} is also what the FIFO stores.
package sec_alert_handler_pkg;

  localparam int ROB_IDX_W_DEF = 6;
  localparam int YROT_W_DEF    = 6;

  typedef struct packed {
    logic [ROB_IDX_W_DEF-1:0] rob_idx;
    logic [YROT_W_DEF-1:0]    yrot;
  } abort_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sec_alert_fifo.sv
// Two-write / one-read FIFO for pending aborts; writes land on the next edge, read is the
// combinational head. free counts the slot released by a same-cycle pop; flush empties it.
module sec_alert_fifo #(
  parameter  int W     = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr0_vld,
  input  logic [W-1:0]  wr0_dat,
  input  logic          wr1_vld,
  input  logic [W-1:0]  wr1_dat,
  input  logic          rd_pop,
  output logic [W-1:0]  rd_dat,
  output logic          empty,
  output logic [AW:0]   free
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   n_wr;
  logic          pop;

  assign empty  = (cnt_q == '0);
  assign pop    = rd_pop && !empty;
  assign rd_dat = mem_q[rptr_q];
  assign free   = (AW+1)'(DEPTH) - cnt_q + (AW+1)'(pop);

  // Callers only raise wr1_vld together with wr0_vld and never exceed free.
  assign n_wr = (AW+1)'(wr0_vld) + (AW+1)'(wr1_vld);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr0_vld) mem_d[wptr_q] = wr0_dat;
      if (wr1_vld) mem_d[wptr_q + AW'(1)] = wr1_dat;
      wptr_d = wptr_q + AW'(n_wr);
      rptr_d = rptr_q + AW'(pop);
      cnt_d  = cnt_q + n_wr - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sec_alert_handler.sv
// Turns security-monitor alert bundles into serialized ROB abort requests (valid one cycle
// after the alert); valid holds until ready, then a fixed hold-off precedes the next request.
module sec_alert_handler
  import sec_alert_handler_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int YROT_W    = YROT_W_DEF,
  parameter int DEPTH     = 4,
  parameter int HOLDOFF   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_sec_alert_alert_valid,
  input  logic [1:0]           io_sec_alert_alert_mask,
  input  logic                 io_sec_alert_aborted_uop_valid_0,
  input  logic                 io_sec_alert_aborted_uop_valid_1,
  input  logic [ROB_IDX_W-1:0] io_sec_alert_aborted_uop_rob_idx_0,
  input  logic [ROB_IDX_W-1:0] io_sec_alert_aborted_uop_rob_idx_1,
  input  logic [YROT_W-1:0]    io_sec_alert_aborted_uop_yrot_0,
  input  logic [YROT_W-1:0]    io_sec_alert_aborted_uop_yrot_1,
  input  logic                 io_flush,
  output logic                 io_abort_valid,
  input  logic                 io_abort_ready,
  output logic [ROB_IDX_W-1:0] io_abort_rob_idx,
  output logic [YROT_W-1:0]    io_abort_yrot,
  output logic                 io_busy,
  output logic                 io_overflow,
  output logic [CNT_W-1:0]     io_alert_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  // Same field order as abort_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [YROT_W-1:0]    yrot;
  } entry_t;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            overflow_q, overflow_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t      ent0, ent1, head, wr0_dat, wr1_dat;
  logic        acc0, acc1;
  logic [1:0]  n_req, n_fit;
  logic [AW:0] free;
  logic        fifo_empty, wr0_vld, wr1_vld, pop, drop;
  logic [CNT_W:0] count_sum;

  assign ent0 = '{rob_idx: io_sec_alert_aborted_uop_rob_idx_0, yrot: io_sec_alert_aborted_uop_yrot_0};
  assign ent1 = '{rob_idx: io_sec_alert_aborted_uop_rob_idx_1, yrot: io_sec_alert_aborted_uop_yrot_1};

  // Port 1 is suppressed when it duplicates an accepted port-0 rob_idx.
  assign acc0 = io_sec_alert_alert_valid && io_sec_alert_alert_mask[0]
             && io_sec_alert_aborted_uop_valid_0;
  assign acc1 = io_sec_alert_alert_valid && io_sec_alert_alert_mask[1]
             && io_sec_alert_aborted_uop_valid_1
             && !(acc0 && (io_sec_alert_aborted_uop_rob_idx_0 == io_sec_alert_aborted_uop_rob_idx_1));

  assign pop   = (state_q == ST_ISSUE) && io_abort_ready;
  assign n_req = {1'b0, acc0} + {1'b0, acc1};

  always_comb begin
    n_fit = n_req;
    if ((AW+1)'(n_req) > free) n_fit = free[1:0];
  end

  // Surviving entries are compacted so a lone port-1 entry uses write slot 0.
  assign wr0_vld = !io_flush && (n_fit != 2'd0);
  assign wr1_vld = !io_flush && (n_fit == 2'd2);
  assign wr0_dat = acc0 ? ent0 : ent1;
  assign wr1_dat = ent1;
  assign drop    = !io_flush && (n_fit != n_req);

  sec_alert_fifo #(
    .W     (ROB_IDX_W + YROT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (io_flush),
    .wr0_vld (wr0_vld),
    .wr0_dat (wr0_dat),
    .wr1_vld (wr1_vld),
    .wr1_dat (wr1_dat),
    .rd_pop  (pop),
    .rd_dat  (head),
    .empty   (fifo_empty),
    .free    (free)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Entries written this cycle count as pending so the request appears one cycle after the alert.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (io_flush) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty || wr0_vld) state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (io_abort_ready) begin
            state_d    = ST_HOLD;
            hold_cnt_d = HC_W'(HOLDOFF - 1);
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_d = (!fifo_empty || wr0_vld) ? ST_ISSUE : ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - HC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    io_abort_valid   = (state_q == ST_ISSUE);
    io_abort_rob_idx = '0;
    io_abort_yrot    = '0;
    if (state_q == ST_ISSUE) begin
      io_abort_rob_idx = head.rob_idx;
      io_abort_yrot    = head.yrot;
    end
    io_busy = !fifo_empty || (state_q != ST_IDLE);
  end

  assign count_sum = {1'b0, count_q} + (CNT_W+1)'(wr0_vld) + (CNT_W+1)'(wr1_vld);

  always_comb begin
    overflow_d = overflow_q || drop;
    count_d    = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign io_overflow    = overflow_q;
  assign io_alert_count = count_q;

endmodule
